screen_sequencer: RTL and testbench

SCREEN_SEQUENCER -- requirements
Module: screen_sequencer

---
 rtl/screen_sequencer.sv | 144 ++++++++++++++
 tb/tb_screen_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/screen_sequencer.sv
// screen_sequencer: menu/help/quiz/result/over screen sequencer for the VGA quiz.
// The internal state reacts to key/answer strobes; the displayed screen
// (screen_sel) only follows it at the frame boundary (DrawX==0, DrawY==480),
// so the visible screen changes at most once per frame.
// Ports:
//   vga_clk, Reset          pixel clock, synchronous active-high reset
//   DrawX, DrawY            current pixel position
//   key_valid, key_code     keyboard strobe and HID code
//   answer_valid/_correct   answer strobe and verdict
//   screen_sel              displayed screen (0 MENU .. 4 OVER)
//   menu_cursor             highlighted menu item (0 START, 1 HELP)
//   score, question_idx     correct answers / answers given this game
//   last_correct            verdict of the most recent answer
//   frame_tick              pulse in the cycle after the frame boundary
//   new_question            pulse when QUIZ becomes displayed
//   busy                    state differs from displayed screen
module screen_sequencer #(
  parameter int NUM_QUESTIONS = 10,
  parameter int RESULT_FRAMES = 120
) (
  input  logic       vga_clk,
  input  logic       Reset,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  input  logic       answer_valid,
  input  logic       answer_correct,
  output logic [2:0] screen_sel,
  output logic [1:0] menu_cursor,
  output logic [3:0] score,
  output logic [3:0] question_idx,
  output logic       last_correct,
  output logic       frame_tick,
  output logic       new_question,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_MENU   = 3'd0,
    S_HELP   = 3'd1,
    S_QUIZ   = 3'd2,
    S_RESULT = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  localparam logic [7:0] KEY_UP    = 8'h52;
  localparam logic [7:0] KEY_DOWN  = 8'h51;
  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_ESC   = 8'h29;

  localparam logic [3:0] NQ = 4'(NUM_QUESTIONS);
  localparam logic [7:0] RF = 8'(RESULT_FRAMES);

  state_t     state;
  logic [7:0] frame_cnt;
  logic [7:0] frame_cnt_inc;
  logic       frame_boundary;
  logic       key_enter;
  logic       key_esc;

  assign frame_boundary = (DrawX == 10'd0) && (DrawY == 10'd480);
  assign busy           = (3'(state) != screen_sel);
  assign frame_cnt_inc  = frame_cnt + 8'd1;
  assign key_enter      = key_valid && (key_code == KEY_ENTER);
  assign key_esc        = key_valid && (key_code == KEY_ESC);

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state        <= S_MENU;
      screen_sel   <= '0;
      menu_cursor  <= '0;
      score        <= '0;
      question_idx <= '0;
      last_correct <= 1'b0;
      frame_cnt    <= '0;
      frame_tick   <= 1'b0;
      new_question <= 1'b0;
    end else begin
      frame_tick   <= frame_boundary;
      new_question <= frame_boundary && (state == S_QUIZ) && (screen_sel != 3'(S_QUIZ));
      if (frame_boundary)
        screen_sel <= 3'(state);

      // Every arm is gated by !busy; the default arm is not, so an
      // undefined encoding recovers even though it always looks busy.
      case (state)
        S_MENU: begin
          if (!busy && key_valid) begin
            case (key_code)
              KEY_UP:   menu_cursor <= 2'd0;
              KEY_DOWN: menu_cursor <= 2'd1;
              KEY_ENTER: begin
                if (menu_cursor == 2'd0) begin
                  state        <= S_QUIZ;
                  score        <= '0;
                  question_idx <= '0;
                end else begin
                  state <= S_HELP;
                end
              end
              default: ;
            endcase
          end
        end
        S_HELP: begin
          if (!busy && (key_esc || key_enter))
            state <= S_MENU;
        end
        S_QUIZ: begin
          // An answer in the same cycle as a key wins; the key is dropped.
          if (!busy && answer_valid) begin
            state        <= S_RESULT;
            last_correct <= answer_correct;
            frame_cnt    <= '0;
            if (question_idx < NQ)
              question_idx <= question_idx + 4'd1;
            if (answer_correct && (score < NQ))
              score <= score + 4'd1;
          end else if (!busy && key_esc) begin
            state <= S_MENU;
          end
        end
        S_RESULT: begin
          // Not busy here implies RESULT is displayed, so each frame_tick
          // (including the one that first shows it) is a displayed frame.
          if (!busy && frame_tick) begin
            frame_cnt <= frame_cnt_inc;
            if (frame_cnt_inc == RF)
              state <= (question_idx >= NQ) ? S_OVER : S_QUIZ;
          end
        end
        S_OVER: begin
          if (!busy && key_enter) begin
            state       <= S_MENU;
            menu_cursor <= 2'd0;
          end
        end
        default: state <= S_MENU;
      endcase
    end
  end

endmodule

// File: tb/tb_screen_sequencer.sv
// tb_screen_sequencer: randomized and directed stimulus for screen_sequencer,
// checked every cycle against a behavioural model of the screen rules.
// Frames are compressed: a boundary pixel is presented every PERIOD cycles.
module tb_screen_sequencer;

  localparam int NQ     = 10;
  localparam int RF     = 2;
  localparam int PERIOD = 20;

  logic       vga_clk = 1'b0;
  logic       Reset;
  logic [9:0] DrawX, DrawY;
  logic       key_valid;
  logic [7:0] key_code;
  logic       answer_valid, answer_correct;
  logic [2:0] screen_sel;
  logic [1:0] menu_cursor;
  logic [3:0] score, question_idx;
  logic       last_correct, frame_tick, new_question, busy;

  screen_sequencer #(.NUM_QUESTIONS(NQ), .RESULT_FRAMES(RF)) dut (
    .vga_clk        (vga_clk),
    .Reset          (Reset),
    .DrawX          (DrawX),
    .DrawY          (DrawY),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .answer_valid   (answer_valid),
    .answer_correct (answer_correct),
    .screen_sel     (screen_sel),
    .menu_cursor    (menu_cursor),
    .score          (score),
    .question_idx   (question_idx),
    .last_correct   (last_correct),
    .frame_tick     (frame_tick),
    .new_question   (new_question),
    .busy           (busy)
  );

  always #5 vga_clk = ~vga_clk;

  int checks   = 0;
  int failures = 0;
  int phase    = 1;
  int nq_pulses = 0;

  // Reference: screens as numbers, "wanted" screen vs "shown" screen.
  int m_want, m_shown, m_cursor, m_score, m_asked, m_last, m_tick, m_newq;
  int m_result_shown_frames;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_want = 0; m_shown = 0; m_cursor = 0; m_score = 0; m_asked = 0;
    m_last = 0; m_tick = 0; m_newq = 0; m_result_shown_frames = 0;
  endtask

  // Applies one clock edge of the screen rules to the model.
  task automatic model_step(input bit rst, input int dx, input int dy,
                            input bit kv, input int kc, input bit av, input bit ac);
    bit at_boundary, pending;
    int want_n, shown_n, cursor_n, score_n, asked_n, last_n, frames_n;
    if (rst) begin
      model_reset();
      return;
    end
    at_boundary = (dx == 0 && dy == 480);
    pending  = (m_want != m_shown);
    want_n = m_want; cursor_n = m_cursor; score_n = m_score;
    asked_n = m_asked; last_n = m_last; frames_n = m_result_shown_frames;
    shown_n = at_boundary ? m_want : m_shown;
    if (!pending) begin
      if (m_want == 0 && kv) begin
        if (kc == 'h52) cursor_n = 0;
        else if (kc == 'h51) cursor_n = 1;
        else if (kc == 'h28) begin
          if (m_cursor == 0) begin want_n = 2; score_n = 0; asked_n = 0; end
          else want_n = 1;
        end
      end else if (m_want == 1 && kv && (kc == 'h28 || kc == 'h29)) begin
        want_n = 0;
      end else if (m_want == 2) begin
        if (av) begin
          want_n = 3; last_n = ac; frames_n = 0;
          asked_n = (m_asked < NQ) ? m_asked + 1 : NQ;
          if (ac) score_n = (m_score < NQ) ? m_score + 1 : NQ;
        end else if (kv && kc == 'h29) want_n = 0;
      end else if (m_want == 3 && m_tick == 1) begin
        frames_n = m_result_shown_frames + 1;
        if (frames_n == RF) want_n = (m_asked == NQ) ? 4 : 2;
      end else if (m_want == 4 && kv && kc == 'h28) begin
        want_n = 0; cursor_n = 0;
      end
    end
    m_newq = (at_boundary && m_want == 2 && m_shown != 2) ? 1 : 0;
    m_tick = at_boundary ? 1 : 0;
    m_want = want_n; m_shown = shown_n; m_cursor = cursor_n; m_score = score_n;
    m_asked = asked_n; m_last = last_n; m_result_shown_frames = frames_n;
  endtask

  task automatic compare_all();
    check("screen_sel",   int'(screen_sel),   m_shown);
    check("menu_cursor",  int'(menu_cursor),  m_cursor);
    check("score",        int'(score),        m_score);
    check("question_idx", int'(question_idx), m_asked);
    check("last_correct", int'(last_correct), m_last);
    check("frame_tick",   int'(frame_tick),   m_tick);
    check("new_question", int'(new_question), m_newq);
    check("busy",         int'(busy),         (m_want != m_shown) ? 1 : 0);
  endtask

  task automatic cycle(input bit kv = 0, input int kc = 0, input bit av = 0,
                       input bit ac = 0, input bit rst = 0);
    int dx, dy, mode;
    if (phase % PERIOD == 0) begin
      dx = 0; dy = 480;
    end else begin
      mode = $urandom_range(0, 7);
      case (mode)
        0: begin dx = 0; dy = 479; end
        1: begin dx = 1; dy = 480; end
        2: begin dx = 0; dy = 481; end
        default: begin dx = $urandom_range(1, 799); dy = $urandom_range(0, 524); end
      endcase
    end
    phase++;
    Reset = rst; DrawX = 10'(dx); DrawY = 10'(dy);
    key_valid = kv; key_code = 8'(kc); answer_valid = av; answer_correct = ac;
    @(posedge vga_clk);
    model_step(rst, dx, dy, kv, kc, av, ac);
    #1;
    if (new_question) nq_pulses++;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Idles until the model shows the target screen, then checks the DUT.
  task automatic wait_shown(input string tag, input int target, input int budget);
    int k = 0;
    while (m_shown != target && k < budget) begin
      cycle();
      k++;
    end
    check(tag, int'(screen_sel), target);
  endtask

  // Steps to a cycle that is not the one just before a boundary.
  task automatic away_from_boundary();
    while ((phase % PERIOD) < 3 || (phase % PERIOD) > PERIOD - 3) cycle();
  endtask

  initial begin
    model_reset();
    Reset = 1'b1; DrawX = '0; DrawY = '0; key_valid = 1'b0; key_code = '0;
    answer_valid = 1'b0; answer_correct = 1'b0;

    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    check("rst_screen", int'(screen_sel), 0);
    check("rst_busy",   int'(busy), 0);
    check("rst_score",  int'(score), 0);
    idle(5);

    // Cursor saturation
    for (int i = 0; i < 3; i++) begin cycle(1, 'h51); idle(2); end
    check("cursor_down3", int'(menu_cursor), 1);
    for (int i = 0; i < 3; i++) begin cycle(1, 'h52); idle(2); end
    check("cursor_up3", int'(menu_cursor), 0);

    // HELP request held until the boundary; a second enter is dropped
    cycle(1, 'h51);
    away_from_boundary();
    cycle(1, 'h28);
    cycle();
    check("pend_busy", int'(busy), 1);
    check("pend_sel",  int'(screen_sel), 0);
    cycle(1, 'h28);
    wait_shown("help_shown", 1, 3 * PERIOD);
    check("help_not_busy", int'(busy), 0);
    idle(PERIOD + 2);
    check("help_held", int'(screen_sel), 1);
    check("help_cursor", int'(menu_cursor), 1);
    cycle(1, 'h29);
    wait_shown("back_menu", 0, 3 * PERIOD);

    // Full game, alternating answers
    cycle(1, 'h52);
    cycle(1, 'h28);
    nq_pulses = 0;
    for (int q = 0; q < NQ; q++) begin
      wait_shown("quiz_shown", 2, 6 * PERIOD);
      idle($urandom_range(0, 5));
      cycle(0, 0, 1, (q % 2 == 0) ? 1'b1 : 1'b0);
      wait_shown("result_shown", 3, 3 * PERIOD);
    end
    wait_shown("over_shown", 4, (RF + 3) * PERIOD);
    check("game_score", int'(score), 5);
    check("game_idx",   int'(question_idx), 10);
    check("game_pulses", nq_pulses, 10);
    idle(PERIOD);
    check("over_hold_score", int'(score), 5);
    cycle(1, 'h28);
    wait_shown("over_to_menu", 0, 3 * PERIOD);

    // Answer beats escape in the same cycle
    cycle(1, 'h28);
    wait_shown("quiz2", 2, 3 * PERIOD);
    cycle(1, 'h29, 1, 1);
    wait_shown("result2", 3, 3 * PERIOD);
    check("same_cycle_score", int'(score), 1);
    wait_shown("back_quiz", 2, (RF + 3) * PERIOD);
    check("not_menu", int'(screen_sel), 2);

    // Reset while RESULT is displayed with score 3
    for (int q = 0; q < 2; q++) begin
      wait_shown("quiz3", 2, (RF + 3) * PERIOD);
      cycle(0, 0, 1, 1);
      wait_shown("result3", 3, 3 * PERIOD);
    end
    check("pre_rst_score", int'(score), 3);
    cycle(0, 0, 0, 0, 1);
    check("mid_rst_sel",   int'(screen_sel), 0);
    check("mid_rst_score", int'(score), 0);
    check("mid_rst_busy",  int'(busy), 0);
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 15000; i++) begin
      bit kv, av, ac, rst;
      int kc, sel;
      kv  = ($urandom_range(0, 5) == 0);
      sel = $urandom_range(0, 9);
      kc  = (sel < 3) ? 'h28 : (sel < 5) ? 'h51 : (sel < 7) ? 'h52 :
            (sel < 8) ? 'h29 : $urandom_range(0, 255);
      av  = ($urandom_range(0, 9) == 0);
      ac  = $urandom_range(0, 1);
      rst = ($urandom_range(0, 799) == 0);
      cycle(kv, kc, av, ac, rst);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
